quadrature_decoder: RTL and testbench
=====================================

QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 SHALL have parameter: FILTER_LEN, 4, consecutive stable clk cycles required before a synchronized input is accepted (range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: quad_a  input  1  encoder channel A, asynchronous to clk.
REQ-005 SHALL have port: quad_b  input  1  encoder channel B, asynchronous to clk.
REQ-006 SHALL have port: err_clr  input  1  synchronous clear of err.
REQ-007 SHALL have port: index  input  1  encoder index pulse, asynchronous to clk; present only with QDEC_INDEX_EN.
REQ-008 SHALL have port: count  output  8  position count.
REQ-009 SHALL have port: up_down  output  1  direction of the last valid step: 0 = up, 1 = down (same encoding as the team's up/down counter).
REQ-010 SHALL have port: step  output  1  one-cycle pulse per valid step.
REQ-011 SHALL have port: err  output  1  sticky illegal-transition flag.

Function
REQ-012 SHALL pass quad_a, quad_b (and index) through a 2-flop synchronizer each.
REQ-013 SHALL accept a synchronized input into its filtered value only after it holds a new value for FILTER_LEN consecutive cycles; shorter glitches are discarded.
REQ-014 SHALL decode filtered {A,B} x4: 00->10->11->01->00 = up (count+1, up_down=0); reverse sequence = down (count-1, up_down=1).
REQ-015 SHALL, on each valid step, update count and up_down and pulse step high for exactly one cycle.
REQ-016 SHALL wrap count modulo 256: 8'hFF up -> 8'h00; 8'h00 down -> 8'hFF; no saturation.
REQ-017 SHALL treat a simultaneous change of both filtered channels as illegal: count, up_down unchanged, no step, err set, decoder state resyncs to the new {A,B}.
REQ-018 SHALL set err on an illegal transition and hold it until err_clr is 1; an illegal transition in the same cycle as err_clr leaves err = 1 (set wins).
REQ-019 SHALL produce count/step change exactly 2 + FILTER_LEN + 1 clk cycles after a clean input edge is first sampled.
REQ-020 SHALL keep count, up_down and step unchanged while filtered {A,B} is unchanged.

Reset
REQ-021 SHALL, while reset is 0, force count=8'h00, up_down=0, step=0, err=0, synchronizers, filters and decoder state to 0 immediately, independent of clk.
REQ-022 SHALL adopt the first filtered {A,B} after reset release as reference state without counting or flagging err, whatever its value.
REQ-023 SHALL discard any partially filtered input on reset mid-operation; no step is produced by an interrupted transition.

Configuration
REQ-024 SHALL compile the index feature only when macro QDEC_INDEX_EN is defined.
REQ-025 SHALL with QDEC_INDEX_EN: synchronize and filter index like quad_a; on filtered rising edge clear count to 8'h00 that cycle; if a valid step occurs the same cycle, count=8'h00 (clear wins) while step and up_down still update.
REQ-026 SHALL without QDEC_INDEX_EN: have no index port and no index logic; count changes only by steps and reset.

Verification
REQ-027 SHALL cover: FILTER_LEN=4, reset then 8 up steps (each phase held 10 cycles) -> count=8'h08, up_down=0, 8 step pulses, each 7 cycles after edge.
REQ-028 SHALL cover: from count=8'h00, one down step -> count=8'hFF, up_down=1; from 8'hFF one up step -> 8'h00.
REQ-029 SHALL cover: 3-cycle glitch on quad_a with FILTER_LEN=4 -> no step, count unchanged, err=0.
REQ-030 SHALL cover: {A,B} 00->11 held 10 cycles -> err=1, count unchanged; err_clr asserted with new illegal event same cycle -> err stays 1; err_clr alone -> err=0.
REQ-031 SHALL cover: reset released with {A,B}=11 -> no step, err=0; reset asserted mid-filter -> all outputs 0 at once, no step after release.
REQ-032 SHALL cover (QDEC_INDEX_EN): count=8'h05, index rising edge coinciding with up step -> count=8'h00, step pulse, up_down=0.

Source files
------------

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: 2-flop synchronizers, FILTER_LEN glitch filter, x4 decode into an 8-bit wrapping count.
// Define QDEC_INDEX_EN to add the index input, which clears the count on its filtered rising edge.
module quadrature_decoder #(
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
`ifdef QDEC_INDEX_EN
  input  logic       index,
`endif
  input  logic       err_clr,
  output logic [7:0] count,
  output logic       up_down,
  output logic       step,
  output logic       err
);

`ifdef QDEC_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif
  localparam logic [3:0] CNT_LAST    = 4'(FILTER_LEN - 1);
  localparam logic [4:0] SETTLE_LAST = 5'(FILTER_LEN + 3);

  logic [NCH-1:0]      raw_in;
  logic [NCH-1:0]      sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [NCH-1:0][3:0] cnt_q, cnt_d;
  logic [1:0]          ab;
  logic [1:0]          state_q, state_d;
  logic                primed_q, primed_d;
  logic [4:0]          settle_q, settle_d;
  logic [7:0]          count_q, count_d;
  logic                up_down_q, up_down_d;
  logic                step_q, step_d;
  logic                err_q, err_d;
`ifdef QDEC_INDEX_EN
  logic                idx_prev_q, idx_prev_d;

  assign raw_in = {index, quad_a, quad_b};
`else
  assign raw_in = {quad_a, quad_b};
`endif
  assign ab = filt_q[1:0];

  // Position of an {A,B} pair along the up sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phase_of(input logic [1:0] ab_v);
    case (ab_v)
      2'b00:   phase_of = 2'd0;
      2'b10:   phase_of = 2'd1;
      2'b11:   phase_of = 2'd2;
      default: phase_of = 2'd3;
    endcase
  endfunction

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  // Until the pipeline has settled after reset, the filtered pair is only adopted as reference.
  always_comb begin
    state_d   = state_q;
    primed_d  = primed_q;
    settle_d  = settle_q;
    count_d   = count_q;
    up_down_d = up_down_q;
    step_d    = 1'b0;
    err_d     = err_clr ? 1'b0 : err_q;
    if (!primed_q) begin
      if (settle_q == SETTLE_LAST) begin
        primed_d = 1'b1;
        state_d  = ab;
      end else begin
        settle_d = settle_q + 5'd1;
      end
    end else if (ab != state_q) begin
      state_d = ab;
      if (ab == ~state_q) begin
        err_d = 1'b1;
      end else begin
        step_d = 1'b1;
        if (phase_of(ab) == phase_of(state_q) + 2'd1) begin
          up_down_d = 1'b0;
          count_d   = count_q + 8'd1;
        end else begin
          up_down_d = 1'b1;
          count_d   = count_q - 8'd1;
        end
      end
    end
`ifdef QDEC_INDEX_EN
    idx_prev_d = filt_q[2];
    if (filt_q[2] && !idx_prev_q) begin
      count_d = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      cnt_q      <= '0;
      state_q    <= 2'b00;
      primed_q   <= 1'b0;
      settle_q   <= 5'd0;
      count_q    <= 8'h00;
      up_down_q  <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef QDEC_INDEX_EN
      idx_prev_q <= 1'b0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      primed_q   <= primed_d;
      settle_q   <= settle_d;
      count_q    <= count_d;
      up_down_q  <= up_down_d;
      step_q     <= step_d;
      err_q      <= err_d;
`ifdef QDEC_INDEX_EN
      idx_prev_q <= idx_prev_d;
`endif
    end
  end

  assign count   = count_q;
  assign up_down = up_down_q;
  assign step    = step_q;
  assign err     = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Testbench for quadrature_decoder: expected steps are queued when encoder phases are driven
// and matched against observed step pulses (count, direction, latency).
module tb_quadrature_decoder;
  localparam int FILTER_LEN = 4;
  localparam int LAT = FILTER_LEN + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       err_clr = 1'b0;
`ifdef QDEC_INDEX_EN
  logic       index = 1'b0;
`endif
  logic [7:0] count;
  logic       up_down;
  logic       step;
  logic       err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] count;
    logic       up_down;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  logic [7:0] m_count = 8'h00;
  logic       m_ud = 1'b0;
  logic [1:0] m_ab = 2'b00;

  quadrature_decoder #(.FILTER_LEN(FILTER_LEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .quad_a  (quad_a),
    .quad_b  (quad_b),
`ifdef QDEC_INDEX_EN
    .index   (index),
`endif
    .err_clr (err_clr),
    .count   (count),
    .up_down (up_down),
    .step    (step),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset === 1'b1 && step === 1'b1) begin
      ev_t o;
      o.count = count;
      o.up_down = up_down;
      o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  function automatic logic [1:0] next_up(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive_ab(input logic [1:0] ab);
    ev_t e;
    {quad_a, quad_b} = ab;
    if (ab != m_ab) begin
      if (ab != ~m_ab) begin
        if (ab == next_up(m_ab)) begin
          m_count = m_count + 8'd1;
          m_ud = 1'b0;
        end else begin
          m_count = m_count - 8'd1;
          m_ud = 1'b1;
        end
        e.count = m_count;
        e.up_down = m_ud;
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      m_ab = ab;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 40) begin
      @(negedge clk);
      n++;
    end
    idle(4);
  endtask

  task automatic restart(input logic [1:0] ab);
    reset = 1'b0;
    {quad_a, quad_b} = ab;
    idle(2);
    reset = 1'b1;
    m_count = 8'h00;
    m_ud = 1'b0;
    m_ab = ab;
    exp_q.delete();
    obs_q.delete();
    idle(20);
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if (count !== 8'h00 || up_down !== 1'b0 || step !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold: count=%0h up_down=%0b step=%0b err=%0b, expected all 0", count, up_down, step, err);
    end
    reset = 1'b1;
    idle(20);
    checks++;
    if (count !== 8'h00 || err !== 1'b0 || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL reset_release: count=%0h err=%0b steps=%0d, expected 0/0/0", count, err, obs_q.size());
    end
  endtask

  task automatic test_up_steps();
    ev_t e, o;
    int n_steps = 0;
    for (int i = 0; i < 8; i++) begin
      drive_ab(next_up(m_ab));
      idle(10);
    end
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL up_step_missing: no pulse, expected count=%0h", e.count);
      end else begin
        o = obs_q.pop_front();
        n_steps++;
        if (o.count !== e.count || o.up_down !== e.up_down || o.cyc - e.cyc != LAT) begin
          failures++;
          $display("[TB] FAIL up_step: count=%0h up_down=%0b latency=%0d, expected %0h/%0b/%0d",
                   o.count, o.up_down, o.cyc - e.cyc, e.count, e.up_down, LAT);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || n_steps != 8 || count !== 8'h08 || up_down !== 1'b0) begin
      failures++;
      $display("[TB] FAIL up_total: pulses=%0d extra=%0d count=%0h up_down=%0b, expected 8/0/08/0",
               n_steps, obs_q.size(), count, up_down);
      obs_q.delete();
    end
  endtask

  task automatic test_wrap();
    ev_t e, o;
    restart(2'b00);
    drive_ab(2'b01);
    idle(10);
    checks++;
    if (count !== 8'hFF || up_down !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap_down: count=%0h up_down=%0b, expected ff/1", count, up_down);
    end
    drive_ab(2'b00);
    idle(10);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL wrap_step_missing: no pulse, expected count=%0h", e.count);
      end else begin
        o = obs_q.pop_front();
        if (o.count !== e.count || o.up_down !== e.up_down || o.cyc - e.cyc != LAT) begin
          failures++;
          $display("[TB] FAIL wrap_step: count=%0h up_down=%0b latency=%0d, expected %0h/%0b/%0d",
                   o.count, o.up_down, o.cyc - e.cyc, e.count, e.up_down, LAT);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || count !== 8'h00 || up_down !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_up: extra=%0d count=%0h up_down=%0b, expected 0/00/0", obs_q.size(), count, up_down);
      obs_q.delete();
    end
  endtask

  task automatic test_glitch();
    ev_t e, o;
    quad_a = 1'b1;
    idle(3);
    quad_a = 1'b0;
    idle(15);
    checks++;
    if (obs_q.size() != 0 || count !== m_count || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL glitch_reject: steps=%0d count=%0h err=%0b, expected 0/%0h/0", obs_q.size(), count, err, m_count);
      obs_q.delete();
    end
    drive_ab(2'b10);
    idle(FILTER_LEN);
    drive_ab(2'b00);
    idle(10);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL glitch_min_missing: no pulse, expected count=%0h", e.count);
      end else begin
        o = obs_q.pop_front();
        if (o.count !== e.count || o.up_down !== e.up_down || o.cyc - e.cyc != LAT) begin
          failures++;
          $display("[TB] FAIL glitch_min_step: count=%0h up_down=%0b latency=%0d, expected %0h/%0b/%0d",
                   o.count, o.up_down, o.cyc - e.cyc, e.count, e.up_down, LAT);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL glitch_min_extra: %0d extra pulses, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_illegal();
    drive_ab(2'b11);
    idle(10);
    checks++;
    if (err !== 1'b1 || count !== m_count || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL illegal_set: err=%0b count=%0h steps=%0d, expected 1/%0h/0", err, count, obs_q.size(), m_count);
    end
    drive_ab(2'b00);
    idle(LAT - 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL illegal_set_wins: err=%0b, expected 1", err);
    end
    idle(3);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    idle(2);
    checks++;
    if (err !== 1'b0 || count !== m_count || obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL illegal_clear: err=%0b count=%0h steps=%0d, expected 0/%0h/0", err, count, obs_q.size(), m_count);
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    ev_t e, o;
    drive_ab(2'b01);
    idle(10);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL mid_pre_missing: no pulse, expected count=%0h", e.count);
      end else begin
        o = obs_q.pop_front();
        if (o.count !== e.count || o.up_down !== e.up_down || o.cyc - e.cyc != LAT) begin
          failures++;
          $display("[TB] FAIL mid_pre_step: count=%0h up_down=%0b latency=%0d, expected %0h/%0b/%0d",
                   o.count, o.up_down, o.cyc - e.cyc, e.count, e.up_down, LAT);
        end
      end
    end
    {quad_a, quad_b} = 2'b11;
    idle(3);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (count !== 8'h00 || up_down !== 1'b0 || step !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_async: count=%0h up_down=%0b step=%0b err=%0b, expected all 0", count, up_down, step, err);
    end
    exp_q.delete();
    obs_q.delete();
    m_count = 8'h00;
    m_ud = 1'b0;
    m_ab = 2'b11;
    idle(2);
    reset = 1'b1;
    idle(25);
    checks++;
    if (obs_q.size() != 0 || err !== 1'b0 || count !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_release: steps=%0d err=%0b count=%0h, expected 0/0/00", obs_q.size(), err, count);
      obs_q.delete();
    end
    drive_ab(2'b01);
    idle(10);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL mid_ref_missing: no pulse, expected count=%0h", e.count);
      end else begin
        o = obs_q.pop_front();
        if (o.count !== e.count || o.up_down !== e.up_down || o.cyc - e.cyc != LAT) begin
          failures++;
          $display("[TB] FAIL mid_ref_step: count=%0h up_down=%0b latency=%0d, expected %0h/%0b/%0d",
                   o.count, o.up_down, o.cyc - e.cyc, e.count, e.up_down, LAT);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_ref_extra: extra=%0d err=%0b, expected 0/0", obs_q.size(), err);
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    logic [1:0] seq [4];
    seq[0] = 2'b11;
    seq[1] = 2'b10;
    seq[2] = 2'b00;
    seq[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      drive_ab(seq[i]);
      idle(FILTER_LEN + 2);
    end
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL b2b_missing: no pulse, expected count=%0h", e.count);
      end else begin
        o = obs_q.pop_front();
        if (o.count !== e.count || o.up_down !== e.up_down || o.cyc - e.cyc != LAT) begin
          failures++;
          $display("[TB] FAIL b2b_step: count=%0h up_down=%0b latency=%0d, expected %0h/%0b/%0d",
                   o.count, o.up_down, o.cyc - e.cyc, e.count, e.up_down, LAT);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || count !== 8'hFD || up_down !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_total: extra=%0d count=%0h up_down=%0b, expected 0/fd/1", obs_q.size(), count, up_down);
      obs_q.delete();
    end
  endtask

`ifdef QDEC_INDEX_EN
  task automatic test_index();
    ev_t e, o;
    restart(2'b00);
    for (int i = 0; i < 5; i++) begin
      drive_ab(next_up(m_ab));
      idle(10);
    end
    wait_drain();
    exp_q.delete();
    obs_q.delete();
    checks++;
    if (count !== 8'h05) begin
      failures++;
      $display("[TB] FAIL index_setup: count=%0h, expected 05", count);
    end
    index = 1'b1;
    drive_ab(next_up(m_ab));
    e = exp_q.pop_back();
    e.count = 8'h00;
    exp_q.push_back(e);
    m_count = 8'h00;
    idle(10);
    index = 1'b0;
    idle(10);
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL index_missing: no pulse, expected count=%0h", e.count);
      end else begin
        o = obs_q.pop_front();
        if (o.count !== e.count || o.up_down !== e.up_down || o.cyc - e.cyc != LAT) begin
          failures++;
          $display("[TB] FAIL index_step: count=%0h up_down=%0b latency=%0d, expected %0h/%0b/%0d",
                   o.count, o.up_down, o.cyc - e.cyc, e.count, e.up_down, LAT);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || count !== 8'h00 || up_down !== 1'b0) begin
      failures++;
      $display("[TB] FAIL index_total: extra=%0d count=%0h up_down=%0b, expected 0/00/0", obs_q.size(), count, up_down);
      obs_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_up_steps();
    test_wrap();
    test_glitch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
`ifdef QDEC_INDEX_EN
    test_index();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
